// File: rtl/dac_spi_tx_if.sv
// Sample-producer <-> DAC SPI transmitter bundle: start request, raw sample,
// and the serial pins plus status returned by the transmitter.
interface dac_spi_tx_if;
  logic        tx_start;
  logic [27:0] data_In;
  logic        CS;
  logic        SCLK;
  logic        SDATA;
  logic        busy;
  logic        tx_done_tick;

  modport master (
    output tx_start, data_In,
    input  CS, SCLK, SDATA, busy, tx_done_tick
  );

  modport slave (
    input  tx_start, data_In,
    output CS, SCLK, SDATA, busy, tx_done_tick
  );
endinterface

// File: rtl/dac_spi_tx.sv
// 16-bit SPI frame transmitter for a 12-bit DAC ({CMD, offset-binary code}).
// Optional DAC_SAT_EN: clamp out-of-range samples instead of wrapping.
module dac_spi_tx #(
  parameter int unsigned DIV = 4,
  parameter logic [3:0]  CMD = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  dac_spi_tx_if.slave bus,
  output logic [1:0]  state_o
);
  // Handshake: tx_start is a request that is taken only when busy=0 (Idle);
  // busy=1 acts as "not ready" and requests seen while it is high are dropped.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t      state_q;
  logic [7:0]  div_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [14:0] shift_q;
  logic        cs_q;
  logic        sclk_q;
  logic        sdata_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] code_d;
  logic        div_wrap;
  logic        unused_bits;

  assign div_wrap    = (div_cnt_q == DIV_M1);
  assign unused_bits = ^{bus.data_In[27:15], bus.data_In[2:0]};

  // Two's complement to offset binary is just an MSB flip.
  always_comb begin
    code_d = {~bus.data_In[14], bus.data_In[13:3]};
`ifdef DAC_SAT_EN
    if (!((&bus.data_In[27:14]) || !(|bus.data_In[27:14])))
      code_d = bus.data_In[27] ? 12'h000 : 12'hFFF;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.tx_start) begin
            shift_q   <= {CMD[2:0], code_d};
            sdata_q   <= CMD[3];
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (div_wrap) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt_q <= '0;
            sclk_q    <= ~sclk_q;
            // Data only moves on the falling SCLK edge so it is stable at each rise.
            if (sclk_q) begin
              if (bit_cnt_q == 4'd15) begin
                cs_q    <= 1'b1;
                sdata_q <= 1'b0;
                state_q <= HOLD;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                sdata_q   <= shift_q[14];
                shift_q   <= {shift_q[13:0], 1'b0};
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (div_wrap) begin
            div_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CS           = cs_q;
  assign bus.SCLK         = sclk_q;
  assign bus.SDATA        = sdata_q;
  assign bus.busy         = busy_q;
  assign bus.tx_done_tick = done_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: one DIV=4 instance for timing/data/reset scenarios and
// one DIV=1 instance for back-to-back streaming.
`timescale 1ns/1ps
module tb_dac_spi_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dac_spi_tx_if if4();
  dac_spi_tx_if if1();
  logic [1:0] st4, st1;

  dac_spi_tx #(.DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(if4), .state_o(st4));
  dac_spi_tx #(.DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1), .state_o(st1));

  int chk = 0;
  int pass = 0;
  logic [15:0] exp_q4[$];
  logic [15:0] exp_q1[$];

  // Frame monitor, index 0 = DIV=4 unit, 1 = DIV=1 unit.
  logic [1:0] cs_s, sclk_s, sd_s, tick_s, busy_s;
  assign cs_s   = {if1.CS, if4.CS};
  assign sclk_s = {if1.SCLK, if4.SCLK};
  assign sd_s   = {if1.SDATA, if4.SDATA};
  assign tick_s = {if1.tx_done_tick, if4.tx_done_tick};
  assign busy_s = {if1.busy, if4.busy};

  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_sd = 2'b00;
  logic [15:0] word [2];
  logic [15:0] last_frame [2];
  int rises[2], last_rises[2], cs_low[2], last_cs_low[2];
  int cs_hi[2], last_gap[2], frames[2], ticks[2], viol[2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (tick_s[u]) ticks[u] <= ticks[u] + 1;
      if (cs_s[u] && sclk_s[u]) viol[u] <= viol[u] + 1;
      if (!cs_s[u]) begin
        if (prev_cs[u]) begin
          word[u] <= '0; rises[u] <= 0; cs_low[u] <= 1; last_gap[u] <= cs_hi[u];
        end else begin
          cs_low[u] <= cs_low[u] + 1;
          if (sclk_s[u] && !prev_sclk[u]) begin
            word[u]  <= {word[u][14:0], sd_s[u]};
            rises[u] <= rises[u] + 1;
            if (sd_s[u] !== prev_sd[u]) viol[u] <= viol[u] + 1;
          end
        end
      end else begin
        cs_hi[u] <= prev_cs[u] ? cs_hi[u] + 1 : 1;
        if (!prev_cs[u]) begin
          last_frame[u] <= word[u]; last_rises[u] <= rises[u];
          last_cs_low[u] <= cs_low[u]; frames[u] <= frames[u] + 1;
        end
      end
      prev_cs[u] <= cs_s[u]; prev_sclk[u] <= sclk_s[u]; prev_sd[u] <= sd_s[u];
    end
  end

  function automatic logic [15:0] model(input logic [27:0] d);
    logic [11:0] c;
    c = {~d[14], d[13:3]};
`ifdef DAC_SAT_EN
    if (d[27:14] != 14'h0000 && d[27:14] != 14'h3FFF) c = d[27] ? 12'h000 : 12'hFFF;
`endif
    return {4'b0011, c};
  endfunction

  function automatic logic [27:0] rand_sample();
    logic [14:0] v;
    v = 15'($urandom_range(0, 32767));
    return {{13{v[14]}}, v};
  endfunction

  // Starts a DIV=4 frame; returns #1 after the accepting edge (edge 0).
  task automatic start4(input logic [27:0] d);
    @(negedge clk);
    if4.data_In = d;
    if4.tx_start = 1'b1;
    @(posedge clk); #1;
    if4.tx_start = 1'b0;
    if4.data_In = 28'($urandom);
  endtask

  task automatic wait_done(input int u, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy_s[u]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if4.tx_start = 1'b0; if4.data_In = '0;
    if1.tx_start = 1'b0; if1.data_In = '0;
    repeat (3) @(negedge clk);
    chk++; if (if4.CS !== 1'b1) $display("FAIL reset_cs4 got=%b want=1", if4.CS); else pass++;
    chk++; if (if4.SCLK !== 1'b0) $display("FAIL reset_sclk4 got=%b want=0", if4.SCLK); else pass++;
    chk++; if (if4.SDATA !== 1'b0) $display("FAIL reset_sdata4 got=%b want=0", if4.SDATA); else pass++;
    chk++; if (if4.busy !== 1'b0) $display("FAIL reset_busy4 got=%b want=0", if4.busy); else pass++;
    chk++; if (if4.tx_done_tick !== 1'b0) $display("FAIL reset_tick4 got=%b want=0", if4.tx_done_tick); else pass++;
    chk++; if (st4 !== 2'd0) $display("FAIL reset_state4 got=%0d want=0", st4); else pass++;
    chk++; if ({if1.CS, if1.SCLK, if1.SDATA, if1.busy, if1.tx_done_tick} !== 5'b10000)
      $display("FAIL reset_pins1 got=%b want=10000", {if1.CS, if1.SCLK, if1.SDATA, if1.busy, if1.tx_done_tick}); else pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_timing();
    int n, bad_busy, f0;
    bit seen;
    logic [15:0] e;
    f0 = frames[0];
    exp_q4.push_back(16'h3800);
    start4(28'h0000000);
    chk++; if ({if4.CS, if4.busy, if4.SDATA} !== 3'b010) $display("FAIL edge0_pins got=%b want=010", {if4.CS, if4.busy, if4.SDATA}); else pass++;
    chk++; if (st4 !== 2'd1) $display("FAIL edge0_state got=%0d want=1", st4); else pass++;
    n = 0; bad_busy = 0; seen = 1'b0;
    while (n < 300 && !seen) begin
      @(posedge clk); #1; n++;
      if (if4.tx_done_tick) seen = 1'b1; else if (!if4.busy) bad_busy++;
    end
    chk++; if (n !== 132) $display("FAIL tick_cycle got=%0d want=132", n); else pass++;
    chk++; if (bad_busy !== 0) $display("FAIL busy_gap got=%0d want=0", bad_busy); else pass++;
    chk++; if ({if4.busy, if4.CS, if4.SDATA, st4} !== 5'b01000) $display("FAIL tick_pins got=%b want=01000", {if4.busy, if4.CS, if4.SDATA, st4}); else pass++;
    @(posedge clk); #1;
    chk++; if (if4.tx_done_tick !== 1'b0) $display("FAIL tick_width got=%b want=0", if4.tx_done_tick); else pass++;
    e = exp_q4.pop_front();
    chk++; if (last_frame[0] !== e) $display("FAIL frame_zero got=%h want=%h", last_frame[0], e); else pass++;
    chk++; if (last_cs_low[0] !== 128) $display("FAIL cs_low got=%0d want=128", last_cs_low[0]); else pass++;
    chk++; if (last_rises[0] !== 16) $display("FAIL rises got=%0d want=16", last_rises[0]); else pass++;
    chk++; if (frames[0] !== f0 + 1) $display("FAIL frame_count got=%0d want=%0d", frames[0], f0 + 1); else pass++;
  endtask

  task automatic test_codes();
    logic [27:0] dv [9];
    logic [15:0] ev [9];
    logic [15:0] e;
    bit ok;
    dv = '{28'hFFFFFF8, 28'h0003FF8, 28'h0010000, 28'hFFF0000, 28'h0004000, 28'h0007FF8,
           28'h0, 28'h0, 28'h0};
`ifdef DAC_SAT_EN
    ev = '{16'h37FF, 16'h3FFF, 16'h3FFF, 16'h3000, 16'h3FFF, 16'h3FFF, 16'h0, 16'h0, 16'h0};
`else
    ev = '{16'h37FF, 16'h3FFF, 16'h3800, 16'h3800, 16'h3000, 16'h37FF, 16'h0, 16'h0, 16'h0};
`endif
    for (int i = 6; i < 9; i++) begin dv[i] = rand_sample(); ev[i] = model(dv[i]); end
    for (int i = 0; i < 9; i++) begin
      exp_q4.push_back(ev[i]);
      start4(dv[i]);
      wait_done(0, 400, ok);
      chk++; if (!ok) $display("FAIL code_timeout idx=%0d got=busy want=idle", i); else pass++;
      e = exp_q4.pop_front();
      chk++; if (last_frame[0] !== e) $display("FAIL code_frame data=%h got=%h want=%h", dv[i], last_frame[0], e); else pass++;
      chk++; if (last_rises[0] !== 16) $display("FAIL code_rises idx=%0d got=%0d want=16", i, last_rises[0]); else pass++;
    end
    chk++; if (viol[0] !== 0) $display("FAIL sclk_sdata_rules got=%0d want=0", viol[0]); else pass++;
  endtask

  task automatic test_ignore_start();
    logic [27:0] a;
    logic [15:0] e;
    int f0;
    bit ok;
    a = 28'h0001238;
    f0 = frames[0];
    exp_q4.push_back(model(a));
    start4(a);
    repeat (19) @(posedge clk);
    #1; if4.data_In = 28'hFFFC000; if4.tx_start = 1'b1;
    @(posedge clk); #1; if4.tx_start = 1'b0;
    wait_done(0, 400, ok);
    chk++; if (!ok) $display("FAIL repulse_timeout got=busy want=idle"); else pass++;
    e = exp_q4.pop_front();
    chk++; if (last_frame[0] !== e) $display("FAIL repulse_frame got=%h want=%h", last_frame[0], e); else pass++;
    repeat (6) @(negedge clk);
    chk++; if (if4.busy !== 1'b0 || frames[0] !== f0 + 1) $display("FAIL repulse_queued got=busy%b/frames%0d want=0/%0d", if4.busy, frames[0], f0 + 1); else pass++;
  endtask

  task automatic test_reset_mid();
    logic [27:0] d;
    logic [15:0] e;
    int t0;
    bit ok;
    t0 = ticks[0];
    start4(28'h0002468);
    repeat (40) @(posedge clk);
    reset = 1'b1;
    #1;
    chk++; if ({if4.CS, if4.SCLK, if4.SDATA, if4.busy, st4} !== 6'b100000)
      $display("FAIL midreset_pins got=%b want=100000", {if4.CS, if4.SCLK, if4.SDATA, if4.busy, st4}); else pass++;
    repeat (3) @(negedge clk);
    chk++; if (ticks[0] !== t0) $display("FAIL midreset_tick got=%0d want=%0d", ticks[0], t0); else pass++;
    d = rand_sample();
    exp_q4.push_back(model(d));
    reset = 1'b0; if4.data_In = d; if4.tx_start = 1'b1;
    @(posedge clk); #1; if4.tx_start = 1'b0;
    chk++; if (if4.busy !== 1'b1) $display("FAIL release_accept got=%b want=1", if4.busy); else pass++;
    wait_done(0, 400, ok);
    chk++; if (!ok) $display("FAIL release_timeout got=busy want=idle"); else pass++;
    e = exp_q4.pop_front();
    chk++; if (last_frame[0] !== e) $display("FAIL release_frame got=%h want=%h", last_frame[0], e); else pass++;
    chk++; if (ticks[0] !== t0 + 1) $display("FAIL release_ticks got=%0d want=%0d", ticks[0], t0 + 1); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [27:0] dv [3];
    logic [15:0] e;
    int acc, done_n, seen_f, t0;
    bit pb;
    for (int i = 0; i < 3; i++) dv[i] = rand_sample();
    t0 = ticks[1];
    seen_f = frames[1];
    @(negedge clk);
    if1.data_In = dv[0]; exp_q1.push_back(model(dv[0])); if1.tx_start = 1'b1;
    acc = 0; done_n = 0; pb = 1'b0;
    for (int c = 0; c < 300 && done_n < 3; c++) begin
      @(negedge clk); #1;
      if (if1.busy && !pb && acc < 3) begin
        acc++;
        if (acc < 3) begin if1.data_In = dv[acc]; exp_q1.push_back(model(dv[acc])); end
        else if1.tx_start = 1'b0;
      end
      pb = if1.busy;
      if (frames[1] != seen_f) begin
        seen_f = frames[1];
        done_n++;
        e = exp_q1.pop_front();
        chk++; if (last_frame[1] !== e) $display("FAIL b2b_frame n=%0d got=%h want=%h", done_n, last_frame[1], e); else pass++;
        chk++; if (last_rises[1] !== 16) $display("FAIL b2b_rises n=%0d got=%0d want=16", done_n, last_rises[1]); else pass++;
        if (done_n > 1) begin
          chk++; if (last_gap[1] !== 2) $display("FAIL b2b_gap n=%0d got=%0d want=2", done_n, last_gap[1]); else pass++;
        end
      end
    end
    if1.tx_start = 1'b0;
    chk++; if (done_n !== 3) $display("FAIL b2b_count got=%0d want=3", done_n); else pass++;
    repeat (4) @(negedge clk);
    chk++; if (ticks[1] !== t0 + 3) $display("FAIL b2b_ticks got=%0d want=%0d", ticks[1], t0 + 3); else pass++;
    chk++; if (viol[1] !== 0) $display("FAIL b2b_rules got=%0d want=0", viol[1]); else pass++;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_codes();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $display("%0d/%0d checks passed", pass, chk + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CMD, default 4'b0011: control nibble sent ahead of the 12 data bits.
REQ-003 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port tx_start, input, 1: one-cycle request to send data_In; ignored while busy=1.
REQ-006 Port data_In, input, 28: signed fixed-point sample, 12 significant bits at [14:3], sign-extended through [27:15].
REQ-007 Port CS, output, 1: DAC chip select, active low, registered.
REQ-008 Port SCLK, output, 1: serial clock, idle low, registered.
REQ-009 Port SDATA, output, 1: serial data, MSB first, registered.
REQ-010 Port busy, output, 1: high while a frame is in progress.
REQ-011 Port tx_done_tick, output, 1: one-cycle pulse on frame completion.

Function
REQ-012 Code conversion SHALL be code[11:0] = {~data_In[14], data_In[13:3]}, giving two's complement to offset binary; data_In[2:0] are discarded.
REQ-013 Frame SHALL be the 16-bit word {CMD, code}, latched in the cycle tx_start is accepted; later data_In changes SHALL NOT affect the frame.
REQ-014 The state machine SHALL have four states: Idle, Setup, Shift, Hold.
REQ-015 Idle: CS=1, SCLK=0, SDATA=0, busy=0; tx_start=1 at edge 0 SHALL move to Setup, with CS=0 and SDATA=frame[15] from edge 0.
REQ-016 Setup: SCLK SHALL stay low until edge DIV, then go to Shift.
REQ-017 Shift: rising edge k (k=1..16) of SCLK SHALL occur at clk edge (2k-1)*DIV and falling edge k at clk edge 2k*DIV.
REQ-018 SDATA SHALL be stable across each SCLK rise; after falling edge k (k=1..15) it SHALL carry frame[15-k].
REQ-019 At edge 32*DIV (16th fall), CS SHALL go high, SDATA SHALL go to 0, and the state SHALL be Hold.
REQ-020 Hold SHALL last DIV cycles; at edge 33*DIV the state SHALL be Idle, with tx_done_tick=1 and busy=0 for exactly that cycle.
REQ-021 busy SHALL be 1 from edge 0 through edge 33*DIV-1.
REQ-022 A tx_start in the tx_done_tick cycle SHALL be accepted and start a back-to-back frame.
REQ-023 tx_start while busy=1 SHALL be ignored, with no queuing.
REQ-024 Exactly 16 SCLK rising edges SHALL occur per frame; SCLK SHALL be low whenever CS is high.

Reset
REQ-025 While reset=1, outputs SHALL be: CS=1, SCLK=0, SDATA=0, busy=0, tx_done_tick=0; state SHALL be Idle, and the divider and bit counters SHALL be cleared.
REQ-026 Reset mid-frame SHALL abort immediately with no tx_done_tick; a tx_start in the first cycle after release SHALL be accepted.

Configuration
REQ-027 With macro DAC_SAT_EN defined: if data_In[27:14] are not all equal, code SHALL saturate to 12'hFFF when data_In[27]=0 and to 12'h000 when data_In[27]=1.
REQ-028 With DAC_SAT_EN undefined: data_In[27:15] SHALL be ignored and REQ-012 applies unconditionally.

Verification
REQ-029 DIV=4, data_In=28'h0000000, tx_start pulse -> SDATA serial frame 16'h3800; CS low 128 cycles; tx_done_tick at cycle 132.
REQ-030 DIV=4, data_In=28'hFFFFFF8 -> frame 16'h37FF; 28'h0003FF8 -> frame 16'h3FFF.
REQ-031 data_In=28'h0010000 -> frame 16'h3FFF with DAC_SAT_EN defined; 16'h3800 without it. data_In=28'hFFF0000 -> frame 16'h3000 with it.
REQ-032 DIV=1, back-to-back: tx_start held high continuously -> frames separated by exactly one CS-high Hold cycle plus the tick cycle, with no extra SCLK edges.
REQ-033 reset=1 at edge 40 of a DIV=4 frame -> CS=1, SCLK=0 same cycle; no tx_done_tick; next frame correct.
REQ-034 tx_start re-pulsed at edge 20 with a different data_In -> ignored; the original frame is unchanged.
